// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the CPU-side bus cycle controller.
package bus_cycle_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BEN_W  = 4;
   localparam int unsigned HALF_W = 16;

   // Active-low byte-enable patterns
   localparam logic [BEN_W-1:0] BEN_NONE = 4'hF;
   localparam logic [BEN_W-1:0] BEN_LO   = 4'b1100;
   localparam logic [BEN_W-1:0] BEN_HI   = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T1B  = 3'd3,
      ST_T2B  = 3'd4,
      ST_DONE = 3'd5
   } bus_state_t;

   // Request latched at acceptance; address kept as a word address
   typedef struct packed {
      logic                  wr;
      logic [ADDR_W-3:0]     a_word;
      logic [BEN_W-1:0]      ben;
      logic [DATA_W-1:0]     wdata;
   } bus_req_t;

   // Byte-lane mask: 8'hFF for every enabled (low) byte enable
   function automatic logic [DATA_W-1:0] ben_mask(input logic [BEN_W-1:0] ben);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < int'(BEN_W); i++) begin
         m[8*i +: 8] = {8{~ben[i]}};
      end
      return m;
   endfunction

   // Lower halfword fully disabled
   function automatic logic lo_off(input logic [BEN_W-1:0] ben);
      return &(ben | BEN_LO);
   endfunction

   // Upper halfword fully disabled
   function automatic logic hi_off(input logic [BEN_W-1:0] ben);
      return &(ben | BEN_HI);
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Consecutive wait-state counter; flags the wait that reaches the limit.
module bus_wait_timer #(
   parameter int unsigned WAIT_LIMIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic clr,
   input  logic inc,
   output logic expired_c
);

   // Counter only needs to reach LIMIT-1; the next increment is the expiring one
   localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
   localparam logic [CNT_W-1:0] LAST = (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

   logic [CNT_W-1:0] count_q;

   // Wait counter: clear on cycle start, saturate at LAST
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (ce) begin
         if (clr) begin
            count_q <= '0;
         end else if (inc && (count_q != LAST)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   // Expiry is the wait that would bring the count to WAIT_LIMIT
   assign expired_c = (WAIT_LIMIT != 0) && inc && (count_q == LAST);

endmodule

// File: rtl/bus_cycle_ctl.sv
// CPU-side bus cycle controller: T1/T2 cycles, wait states, 16-bit split.
module bus_cycle_ctl
   import bus_cycle_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 0
) (
   input  logic              CLK,
   input  logic              RESn,
   input  logic              CE,
   input  logic              REQ,
   input  logic              REQ_WR,
   input  logic [ADDR_W-1:0] REQ_A,
   input  logic [BEN_W-1:0]  REQ_BEn,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              ACK,
   output logic              ERR,
   output logic [DATA_W-1:0] RDATA,
   output logic              BUSY,
   output logic [ADDR_W-1:0] BUS_A,
   output logic              BUS_DAn,
   output logic [BEN_W-1:0]  BUS_BEn,
   output logic              BUS_RW,
   output logic [DATA_W-1:0] BUS_DO,
   input  logic [DATA_W-1:0] BUS_DI,
   input  logic              BUS_READYn,
   input  logic              BUS_SZRQn
);

   bus_state_t        state_q, state_d;
   bus_req_t          req_q, req_d;
   logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

   logic              ack_d, err_d, busy_d, bus_dan_d, bus_rw_d;
   logic [DATA_W-1:0] rdata_d, bus_do_d;
   logic [ADDR_W-1:0] bus_a_d;
   logic [BEN_W-1:0]  bus_ben_d;
   logic              to_err;

   logic              timer_clr, timer_inc, timer_exp_c;
   logic [DATA_W-1:0] mask_c, first_half_c, dup_hi_c;
   logic              upper_only_c, both_c;
   logic              unused_addr_lsb;

   // Byte address bits below the word are not used on this bus
   assign unused_addr_lsb = ^REQ_A[1:0];

   // Lane helpers derived from the latched request
   assign mask_c       = ben_mask(req_q.ben);
   assign upper_only_c = lo_off(req_q.ben) && !hi_off(req_q.ben);
   assign both_c       = !lo_off(req_q.ben) && !hi_off(req_q.ben);
   assign dup_hi_c     = {req_q.wdata[DATA_W-1:HALF_W], req_q.wdata[DATA_W-1:HALF_W]};

   // First-cycle read steering: a 16-bit slave returns its halfword on DI[15:0]
   always_comb begin
      first_half_c = '0;
      if (BUS_SZRQn) begin
         first_half_c = BUS_DI & mask_c;
      end else if (upper_only_c) begin
         first_half_c = {BUS_DI[HALF_W-1:0], HALF_W'(0)} & mask_c;
      end else begin
         first_half_c = {HALF_W'(0), BUS_DI[HALF_W-1:0]} & mask_c;
      end
   end

   // Waits counted in T2/T2B only; counter restarts on each T1/T1B entry
   assign timer_inc = ((state_q == ST_T2) || (state_q == ST_T2B)) && BUS_READYn;
   assign timer_clr = (state_d == ST_T1) || (state_d == ST_T1B);

   bus_wait_timer #(
      .WAIT_LIMIT(WAIT_LIMIT)
   ) u_wait_timer (
      .clk      (CLK),
      .rst_n    (RESn),
      .ce       (CE),
      .clr      (timer_clr),
      .inc      (timer_inc),
      .expired_c(timer_exp_c)
   );

   // Next state and next registered outputs
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rd_buf_d  = rd_buf_q;
      to_err    = 1'b0;
      rdata_d   = RDATA;
      bus_a_d   = BUS_A;
      bus_ben_d = BUS_BEn;
      bus_rw_d  = BUS_RW;
      bus_do_d  = BUS_DO;

      unique case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               req_d.wr     = REQ_WR;
               req_d.a_word = REQ_A[ADDR_W-1:2];
               req_d.ben    = REQ_BEn;
               req_d.wdata  = REQ_WDATA;
               rd_buf_d     = '0;
               state_d      = (REQ_BEn == BEN_NONE) ? ST_DONE : ST_T1;
            end
         end
         ST_T1: state_d = ST_T2;
         ST_T2: begin
            if (BUS_READYn) begin
               if (timer_exp_c) begin
                  state_d = ST_DONE;
                  to_err  = 1'b1;
               end
            end else begin
               if (!req_q.wr) begin
                  rd_buf_d = first_half_c;
               end
               state_d = (!BUS_SZRQn && both_c) ? ST_T1B : ST_DONE;
            end
         end
         ST_T1B: state_d = ST_T2B;
         ST_T2B: begin
            if (BUS_READYn) begin
               if (timer_exp_c) begin
                  state_d = ST_DONE;
                  to_err  = 1'b1;
               end
            end else begin
               if (!req_q.wr) begin
                  rd_buf_d = {BUS_DI[HALF_W-1:0] & mask_c[DATA_W-1:HALF_W],
                              rd_buf_q[HALF_W-1:0]};
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ack_d     = (state_d == ST_DONE);
      err_d     = (state_d == ST_DONE) && to_err;
      busy_d    = (state_d != ST_IDLE);
      bus_dan_d = !((state_d == ST_T2) || (state_d == ST_T2B));

      // Read data is published only on a successful completion
      if ((state_d == ST_DONE) && !to_err && !req_d.wr) begin
         rdata_d = rd_buf_d;
      end

      unique case (state_d)
         ST_T1: begin
            bus_a_d   = {req_d.a_word, 2'b00};
            bus_ben_d = req_d.ben;
            bus_rw_d  = ~req_d.wr;
         end
         ST_T1B: begin
            bus_a_d   = {req_q.a_word, 2'b10};
            bus_ben_d = {req_q.ben[3:2], 2'b11};
         end
         ST_T2:   bus_do_d  = upper_only_c ? dup_hi_c : req_q.wdata;
         ST_T2B:  bus_do_d  = dup_hi_c;
         ST_DONE: bus_ben_d = BEN_NONE;
         ST_IDLE: bus_ben_d = BEN_NONE;
         default: bus_ben_d = BEN_NONE;
      endcase
   end

   // State and output registers; CE freezes everything except reset
   always_ff @(posedge CLK) begin
      if (!RESn) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         rd_buf_q <= '0;
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         RDATA    <= '0;
         BUSY     <= 1'b0;
         BUS_A    <= '0;
         BUS_DAn  <= 1'b1;
         BUS_BEn  <= BEN_NONE;
         BUS_RW   <= 1'b1;
         BUS_DO   <= '0;
      end else if (CE) begin
         state_q  <= state_d;
         req_q    <= req_d;
         rd_buf_q <= rd_buf_d;
         ACK      <= ack_d;
         ERR      <= err_d;
         RDATA    <= rdata_d;
         BUSY     <= busy_d;
         BUS_A    <= bus_a_d;
         BUS_DAn  <= bus_dan_d;
         BUS_BEn  <= bus_ben_d;
         BUS_RW   <= bus_rw_d;
         BUS_DO   <= bus_do_d;
      end
   end

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Directed bench for bus_cycle_ctl with a behavioural 32/16-bit slave.
module tb_bus_cycle_ctl;

   logic        CLK, RESn, CE;
   logic        REQ, REQ_WR;
   logic [31:0] REQ_A, REQ_WDATA;
   logic [3:0]  REQ_BEn;
   logic        ACK, ERR, BUSY;
   logic [31:0] RDATA, BUS_A, BUS_DO, BUS_DI;
   logic        BUS_DAn, BUS_RW, BUS_READYn, BUS_SZRQn;
   logic [3:0]  BUS_BEn;

   int errors = 0;
   int checks = 0;

   // Slave model controls and cycle log
   int          ws = 0;
   logic        dw16 = 1'b0;
   logic        stuck = 1'b0;
   logic [31:0] mem = 32'h0;
   int          wcnt = 0;
   int          dan_low = 0;
   int          cyc_n = 0;
   logic [31:0] cyc_a [4];
   logic [31:0] cyc_do [4];
   logic [3:0]  cyc_ben [4];
   logic        cyc_rw [4];
   logic        up_half;

   bus_cycle_ctl #(.WAIT_LIMIT(4)) dut (
      .CLK(CLK), .RESn(RESn), .CE(CE), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_A(REQ_A),
      .REQ_BEn(REQ_BEn), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
      .BUSY(BUSY), .BUS_A(BUS_A), .BUS_DAn(BUS_DAn), .BUS_BEn(BUS_BEn), .BUS_RW(BUS_RW),
      .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_READYn(BUS_READYn), .BUS_SZRQn(BUS_SZRQn)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Slave: answers mid-cycle so inputs are stable at the next rising edge
   always @(negedge CLK) begin
      up_half   = BUS_A[1] | (BUS_BEn[1:0] == 2'b11);
      BUS_SZRQn = ~dw16;
      BUS_DI    = dw16 ? (up_half ? {16'hA5A5, mem[31:16]} : {16'hA5A5, mem[15:0]}) : mem;
      if (CE) begin
         if (BUS_DAn) begin
            wcnt       = 0;
            BUS_READYn = 1'b1;
         end else begin
            dan_low++;
            if (stuck || (wcnt < ws)) begin
               BUS_READYn = 1'b1;
               wcnt++;
            end else begin
               BUS_READYn = 1'b0;
               if (cyc_n < 4) begin
                  cyc_a[cyc_n]   = BUS_A;
                  cyc_do[cyc_n]  = BUS_DO;
                  cyc_ben[cyc_n] = BUS_BEn;
                  cyc_rw[cyc_n]  = BUS_RW;
               end
               cyc_n++;
            end
         end
      end
   end

   // One request, held until ACK; returns cycles from REQ to ACK
   task automatic do_access(input logic wr, input logic [31:0] a, input logic [3:0] ben,
                            input logic [31:0] wd, output int lat, output logic busy_ok);
      @(posedge CLK); #1;
      dan_low = 0;
      cyc_n   = 0;
      REQ = 1'b1; REQ_WR = wr; REQ_A = a; REQ_BEn = ben; REQ_WDATA = wd;
      lat = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge CLK); #1;
         lat++;
         if (!ACK && !BUSY) busy_ok = 1'b0;
      end while (!ACK && (lat < 40));
      if (!ACK) begin
         checks++; errors++;
         $display("FAIL ack_bound: ACK=%0b after %0d cycles, required 1", ACK, lat);
      end
      REQ = 1'b0;
   endtask

   task automatic test_reset();
      RESn = 1'b0; CE = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (BUS_DAn !== 1'b1)     begin errors++; $display("FAIL rst_dan: got %b want 1", BUS_DAn); end
      checks++; if (BUS_BEn !== 4'hF)     begin errors++; $display("FAIL rst_ben: got %h want f", BUS_BEn); end
      checks++; if (BUS_A !== 32'h0)      begin errors++; $display("FAIL rst_a: got %h want 0", BUS_A); end
      checks++; if (BUS_RW !== 1'b1)      begin errors++; $display("FAIL rst_rw: got %b want 1", BUS_RW); end
      checks++; if (BUS_DO !== 32'h0)     begin errors++; $display("FAIL rst_do: got %h want 0", BUS_DO); end
      checks++; if (ACK !== 1'b0)         begin errors++; $display("FAIL rst_ack: got %b want 0", ACK); end
      checks++; if (ERR !== 1'b0)         begin errors++; $display("FAIL rst_err: got %b want 0", ERR); end
      checks++; if (RDATA !== 32'h0)      begin errors++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
      checks++; if (BUSY !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
      RESn = 1'b1; CE = 1'b1;
   endtask

   task automatic test_read32();
      int lat; logic bok;
      ws = 0; dw16 = 1'b0; mem = 32'hDEADBEEF;
      do_access(1'b0, 32'h100, 4'b0000, 32'h0, lat, bok);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL r32_lat: got %0d want 3", lat); end
      checks++; if (RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL r32_rdata: got %h want deadbeef", RDATA); end
      checks++; if (ERR !== 1'b0)           begin errors++; $display("FAIL r32_err: got %b want 0", ERR); end
      checks++; if (dan_low !== 1)          begin errors++; $display("FAIL r32_t2: got %0d want 1", dan_low); end
      checks++; if (bok !== 1'b1)           begin errors++; $display("FAIL r32_busy: got %b want 1", bok); end
      checks++; if ((cyc_a[0] !== 32'h100) || (cyc_ben[0] !== 4'h0) || (cyc_rw[0] !== 1'b1))
         begin errors++; $display("FAIL r32_bus: got a=%h ben=%h rw=%b want 100/0/1", cyc_a[0], cyc_ben[0], cyc_rw[0]); end
      @(posedge CLK); #1;
      checks++; if ((ACK !== 1'b0) || (BUSY !== 1'b0))
         begin errors++; $display("FAIL r32_pulse: got ack=%b busy=%b want 0/0", ACK, BUSY); end
   endtask

   task automatic test_wait();
      int lat; logic bok;
      ws = 1; dw16 = 1'b0; mem = 32'hDEADBEEF;
      do_access(1'b0, 32'h100, 4'b0000, 32'h0, lat, bok);
      checks++; if (lat !== 4)              begin errors++; $display("FAIL ws1_lat: got %0d want 4", lat); end
      checks++; if (dan_low !== 2)          begin errors++; $display("FAIL ws1_dan: got %0d want 2", dan_low); end
      checks++; if (RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL ws1_rdata: got %h want deadbeef", RDATA); end
      ws = 0;
   endtask

   task automatic test_write16();
      int lat; logic bok;
      dw16 = 1'b1;
      do_access(1'b1, 32'h100, 4'b0000, 32'h12345678, lat, bok);
      checks++; if (cyc_n !== 2) begin errors++; $display("FAIL w16_cycles: got %0d want 2", cyc_n); end
      checks++; if ((cyc_a[0] !== 32'h100) || (cyc_ben[0] !== 4'h0) || (cyc_do[0] !== 32'h12345678) || (cyc_rw[0] !== 1'b0))
         begin errors++; $display("FAIL w16_first: got a=%h ben=%h do=%h rw=%b", cyc_a[0], cyc_ben[0], cyc_do[0], cyc_rw[0]); end
      checks++; if ((cyc_a[1] !== 32'h102) || (cyc_ben[1] !== 4'b0011) || (cyc_do[1] !== 32'h12341234))
         begin errors++; $display("FAIL w16_second: got a=%h ben=%h do=%h want 102/3/12341234", cyc_a[1], cyc_ben[1], cyc_do[1]); end
      checks++; if (lat !== 5)              begin errors++; $display("FAIL w16_lat: got %0d want 5", lat); end
      checks++; if (RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL w16_rdata_hold: got %h want deadbeef", RDATA); end
      @(posedge CLK); #1;
      checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL w16_single_ack: got %b want 0", ACK); end
   endtask

   task automatic test_read16();
      int lat; logic bok;
      dw16 = 1'b1; mem = 32'hCAFEF00D;
      do_access(1'b0, 32'h100, 4'b0000, 32'h0, lat, bok);
      checks++; if (cyc_n !== 2)            begin errors++; $display("FAIL r16_cycles: got %0d want 2", cyc_n); end
      checks++; if (RDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL r16_rdata: got %h want cafef00d", RDATA); end
      do_access(1'b0, 32'h100, 4'b0011, 32'h0, lat, bok);
      checks++; if (cyc_n !== 1)            begin errors++; $display("FAIL up16_cycles: got %0d want 1", cyc_n); end
      checks++; if (lat !== 3)              begin errors++; $display("FAIL up16_lat: got %0d want 3", lat); end
      checks++; if (RDATA !== 32'hCAFE0000) begin errors++; $display("FAIL up16_rdata: got %h want cafe0000", RDATA); end
      dw16 = 1'b0;
   endtask

   task automatic test_timeout();
      int lat; logic bok;
      stuck = 1'b1;
      do_access(1'b0, 32'h200, 4'b0000, 32'h0, lat, bok);
      checks++; if (ERR !== 1'b1)           begin errors++; $display("FAIL tmo_err: got %b want 1", ERR); end
      checks++; if (dan_low !== 4)          begin errors++; $display("FAIL tmo_waits: got %0d want 4", dan_low); end
      checks++; if (lat !== 6)              begin errors++; $display("FAIL tmo_lat: got %0d want 6", lat); end
      checks++; if (RDATA !== 32'hCAFE0000) begin errors++; $display("FAIL tmo_rdata_hold: got %h want cafe0000", RDATA); end
      stuck = 1'b0;
   endtask

   task automatic test_lanes();
      int lat; logic bok;
      mem = 32'hDEADBEEF;
      do_access(1'b0, 32'h104, 4'b1110, 32'h0, lat, bok);
      checks++; if (RDATA !== 32'h000000EF) begin errors++; $display("FAIL byte0_rdata: got %h want 000000ef", RDATA); end
      checks++; if (ERR !== 1'b0)           begin errors++; $display("FAIL byte0_err: got %b want 0", ERR); end
      do_access(1'b0, 32'h108, 4'hF, 32'h0, lat, bok);
      checks++; if (lat !== 1)              begin errors++; $display("FAIL noben_lat: got %0d want 1", lat); end
      checks++; if (cyc_n !== 0)            begin errors++; $display("FAIL noben_cycles: got %0d want 0", cyc_n); end
      checks++; if (RDATA !== 32'h0)        begin errors++; $display("FAIL noben_rdata: got %h want 0", RDATA); end
   endtask

   task automatic test_ce_hold();
      int n;
      mem = 32'h0BADC0DE;
      @(posedge CLK); #1;
      REQ = 1'b1; REQ_WR = 1'b0; REQ_A = 32'h10; REQ_BEn = 4'h0;
      n = 0;
      do begin @(posedge CLK); #1; n++; end while (!ACK && (n < 40));
      CE = 1'b0; REQ = 1'b0;
      repeat (3) begin
         @(posedge CLK); #1;
         checks++; if ((ACK !== 1'b1) || (BUSY !== 1'b1))
            begin errors++; $display("FAIL ce_hold: got ack=%b busy=%b want 1/1", ACK, BUSY); end
      end
      CE = 1'b1;
      @(posedge CLK); #1;
      checks++; if (ACK !== 1'b0)           begin errors++; $display("FAIL ce_release: got %b want 0", ACK); end
      checks++; if (RDATA !== 32'h0BADC0DE) begin errors++; $display("FAIL ce_rdata: got %h want 0badc0de", RDATA); end
   endtask

   task automatic test_reset_mid();
      int n; int acks;
      stuck = 1'b1;
      @(posedge CLK); #1;
      REQ = 1'b1; REQ_WR = 1'b1; REQ_A = 32'h300; REQ_BEn = 4'h0; REQ_WDATA = 32'h55AA55AA;
      n = 0;
      do begin @(posedge CLK); #1; n++; end while (BUS_DAn && (n < 20));
      checks++; if (BUS_DAn !== 1'b0) begin errors++; $display("FAIL mid_t2: got dan=%b want 0", BUS_DAn); end
      RESn = 1'b0;
      @(posedge CLK); #1;
      checks++; if ((BUS_DAn !== 1'b1) || (BUS_BEn !== 4'hF) || (BUSY !== 1'b0))
         begin errors++; $display("FAIL mid_abort: got dan=%b ben=%h busy=%b want 1/f/0", BUS_DAn, BUS_BEn, BUSY); end
      RESn = 1'b1; REQ = 1'b0; stuck = 1'b0;
      acks = 0;
      repeat (5) begin @(posedge CLK); #1; if (ACK) acks++; end
      checks++; if (acks !== 0) begin errors++; $display("FAIL mid_noack: got %0d acks want 0", acks); end
   endtask

   task automatic test_back_to_back();
      int lat; logic bok;
      mem = 32'h11223344;
      do_access(1'b0, 32'h400, 4'h0, 32'h0, lat, bok);
      checks++; if ((lat !== 3) || (RDATA !== 32'h11223344))
         begin errors++; $display("FAIL b2b_first: got lat=%0d rdata=%h want 3/11223344", lat, RDATA); end
      mem = 32'h99887766;
      do_access(1'b0, 32'h404, 4'h0, 32'h0, lat, bok);
      checks++; if ((lat !== 3) || (RDATA !== 32'h99887766))
         begin errors++; $display("FAIL b2b_second: got lat=%0d rdata=%h want 3/99887766", lat, RDATA); end
   endtask

   initial begin
      RESn = 1'b0; CE = 1'b1; REQ = 1'b0; REQ_WR = 1'b0; REQ_A = '0; REQ_BEn = 4'hF;
      REQ_WDATA = '0; BUS_READYn = 1'b1; BUS_SZRQn = 1'b1; BUS_DI = '0;
      test_reset();
      test_read32();
      test_wait();
      test_write16();
      test_read16();
      test_timeout();
      test_lanes();
      test_ce_hold();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
